// File: rtl/endstop_conditioner.sv
// Endstop/limit-switch conditioner: 2-flop sync, stability-counter debounce, set/reset pulses.
// Optional rejected-transition counter when ENDSTOP_GLITCH_COUNT_EN is defined.
module endstop_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1,
  localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_switch_raw,
  input  logic       i_clear,
  output logic       o_level,
  output logic       o_set_pulse,
`ifdef ENDSTOP_GLITCH_COUNT_EN
  output logic [7:0] o_glitch_count,
`endif
  output logic       o_reset_pulse
);

  typedef enum logic [1:0] {
    REL_STABLE  = 2'd0,
    PRESS_CHECK = 2'd1,
    PRS_STABLE  = 2'd2,
    REL_CHECK   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             RAW_REL  = ACTIVE_LOW;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sync1, r_sync2, r_clear_d;
  logic             r_level, r_set_pulse, r_reset_pulse;
  logic             w_s, w_clear_rise, w_set_evt;

  // Synchronisers start at the released level so reset never looks like a press.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1   <= RAW_REL;
      r_sync2   <= RAW_REL;
      r_clear_d <= 1'b0;
    end else begin
      r_sync1   <= i_switch_raw;
      r_sync2   <= r_sync1;
      r_clear_d <= i_clear;
    end
  end

  assign w_s          = ACTIVE_LOW ? ~r_sync2 : r_sync2;
  assign w_clear_rise = i_clear & ~r_clear_d;
  assign w_set_evt    = (r_state == PRESS_CHECK) && w_s && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= REL_STABLE;
      r_cnt         <= '0;
      r_level       <= 1'b0;
      r_set_pulse   <= 1'b0;
      r_reset_pulse <= 1'b0;
    end else begin
      r_set_pulse   <= 1'b0;
      // Set wins over a coincident clear; a clear while pressed is dropped.
      r_reset_pulse <= w_clear_rise & ~r_level & ~w_set_evt;
      case (r_state)
        REL_STABLE: if (w_s) begin
          r_state <= PRESS_CHECK;
          r_cnt   <= CNT_ONE;
        end
        PRESS_CHECK: if (!w_s) begin
          r_state <= REL_STABLE;
          r_cnt   <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_state     <= PRS_STABLE;
          r_cnt       <= '0;
          r_level     <= 1'b1;
          r_set_pulse <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_ONE;
        end
        PRS_STABLE: if (!w_s) begin
          r_state <= REL_CHECK;
          r_cnt   <= CNT_ONE;
        end
        REL_CHECK: if (w_s) begin
          r_state <= PRS_STABLE;
          r_cnt   <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_state <= REL_STABLE;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end else begin
          r_cnt <= r_cnt + CNT_ONE;
        end
        default: begin
          r_state <= REL_STABLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_level       = r_level;
  assign o_set_pulse   = r_set_pulse;
  assign o_reset_pulse = r_reset_pulse;

`ifdef ENDSTOP_GLITCH_COUNT_EN
  logic       w_glitch;
  logic [7:0] r_glitch_count;

  assign w_glitch = ((r_state == PRESS_CHECK) && !w_s) || ((r_state == REL_CHECK) && w_s);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                              r_glitch_count <= 8'd0;
    else if (w_glitch && r_glitch_count != 8'hFF) r_glitch_count <= r_glitch_count + 8'd1;
  end

  assign o_glitch_count = r_glitch_count;
`endif

endmodule

// File: tb/tb_endstop_conditioner.sv
// Directed bench for endstop_conditioner with DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
// Glitch-counter checks are active when ENDSTOP_GLITCH_COUNT_EN is defined.
module tb_endstop_conditioner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raw = 1'b1;
  logic clear = 1'b0;
  logic level, set_pulse, reset_pulse;
`ifdef ENDSTOP_GLITCH_COUNT_EN
  logic [7:0] glitch_count;
`endif
  int tests_run = 0;
  int tests_failed = 0;

  endstop_conditioner #(.DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut (
    .i_clk(clk), .i_reset(rst), .i_switch_raw(raw), .i_clear(clear),
    .o_level(level), .o_set_pulse(set_pulse),
`ifdef ENDSTOP_GLITCH_COUNT_EN
    .o_glitch_count(glitch_count),
`endif
    .o_reset_pulse(reset_pulse)
  );

  always #5 clk = ~clk;

  // One posedge passes; outputs are then sampled at the following negedge.
  task automatic step;
    @(negedge clk);
  endtask

  task automatic apply_reset;
    rst = 1'b1; raw = 1'b1; clear = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    step();
    tests_run++;
    if ({level, set_pulse, reset_pulse} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%b exp=000", {level, set_pulse, reset_pulse});
    end
`ifdef ENDSTOP_GLITCH_COUNT_EN
    tests_run++;
    if (glitch_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_glitch got=%0d exp=0", glitch_count);
    end
`endif
    rst = 1'b0;
    repeat (3) step();
  endtask

  // Press and hold; a clear rising on the same edge as the set is suppressed.
  task automatic test_press;
    raw = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 6) clear = 1'b1;
      step();
      tests_run++;
      if (set_pulse !== (k == 6) || level !== (k >= 6) || reset_pulse !== 1'b0) begin
        tests_failed++;
        $display("FAIL press_edge%0d got sp=%b lv=%b rp=%b exp sp=%b lv=%b rp=0",
                 k, set_pulse, level, reset_pulse, (k == 6), (k >= 6));
      end
    end
    clear = 1'b0;
    step();
  endtask

  task automatic test_clear;
    clear = 1'b1; step();
    tests_run++;
    if (reset_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_while_pressed got=%b exp=0", reset_pulse);
    end
    clear = 1'b0; step();
    raw = 1'b1;
    repeat (8) step();
    tests_run++;
    if (level !== 1'b0) begin
      tests_failed++;
      $display("FAIL release_level got=%b exp=0", level);
    end
    clear = 1'b1; step();
    tests_run++;
    if (reset_pulse !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_released got=%b exp=1", reset_pulse);
    end
    step();
    tests_run++;
    if (reset_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_one_cycle got=%b exp=0", reset_pulse);
    end
    clear = 1'b0; step();
  endtask

  task automatic test_clear_hold;
    int rp = 0, sp = 0;
    clear = 1'b1;
    step(); rp += reset_pulse; sp += set_pulse;
    for (int ph = 0; ph < 4; ph++) begin
      raw = ph[0];
      repeat (8) begin step(); rp += reset_pulse; sp += set_pulse; end
    end
    tests_run++;
    if (rp != 1) begin
      tests_failed++;
      $display("FAIL clear_hold_rp got=%0d exp=1", rp);
    end
    tests_run++;
    if (sp != 2) begin
      tests_failed++;
      $display("FAIL clear_hold_sp got=%0d exp=2", sp);
    end
    clear = 1'b0; step();
  endtask

  task automatic test_glitch;
    int sp = 0;
    apply_reset();
    repeat (3) step();
    raw = 1'b0;
    repeat (3) step();
    raw = 1'b1;
    repeat (10) begin step(); sp += set_pulse; end
    tests_run++;
    if (sp != 0 || level !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_reject got sp=%0d lv=%b exp sp=0 lv=0", sp, level);
    end
`ifdef ENDSTOP_GLITCH_COUNT_EN
    tests_run++;
    if (glitch_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL glitch_count1 got=%0d exp=1", glitch_count);
    end
`endif
  endtask

  task automatic test_reset_mid;
    apply_reset();
    repeat (3) step();
    raw = 1'b0;
    repeat (4) step();
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({level, set_pulse, reset_pulse} !== 3'b000) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs got=%b exp=000", {level, set_pulse, reset_pulse});
    end
    step(); step();
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      tests_run++;
      if (set_pulse !== (k == 6)) begin
        tests_failed++;
        $display("FAIL mid_reset_edge%0d got sp=%b exp=%b", k, set_pulse, (k == 6));
      end
    end
  endtask

  task automatic test_toggle;
    int sp = 0, lv = 0;
    apply_reset();
    repeat (3) step();
    for (int blk = 0; blk < 2; blk++) begin
      for (int i = 0; i < 300; i++) begin
        raw = i[0];
        step(); sp += set_pulse; lv += level;
      end
      raw = 1'b1;
      repeat (4) begin step(); sp += set_pulse; lv += level; end
`ifdef ENDSTOP_GLITCH_COUNT_EN
      tests_run++;
      if (glitch_count !== ((blk == 0) ? 8'd150 : 8'd255)) begin
        tests_failed++;
        $display("FAIL toggle_glitch%0d got=%0d exp=%0d", blk, glitch_count,
                 (blk == 0) ? 150 : 255);
      end
`endif
    end
    tests_run++;
    if (sp != 0 || lv != 0) begin
      tests_failed++;
      $display("FAIL toggle_quiet got sp=%0d lv=%0d exp 0 0", sp, lv);
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_clear();
    test_clear_hold();
    test_glitch();
    test_reset_mid();
    test_toggle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
